// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential radix-4 Booth multiplier.
// Holds the FSM state encoding and the recoded Booth digit control words.
package mult_pkg;

    typedef logic [1:0] state_t;

    localparam state_t StIdle = 2'd0;
    localparam state_t StCalc = 2'd1;
    localparam state_t StDone = 2'd2;

    // Booth digit controls: selected multiple is (zero ? 0 : (neg ? -1 : 1) * (dbl ? 2 : 1) * M)
    typedef struct packed {
        logic neg;
        logic dbl;
        logic zero;
    } booth_ctrl_t;

    localparam booth_ctrl_t BoothZero = 3'b001;
    localparam booth_ctrl_t BoothPos1 = 3'b000;
    localparam booth_ctrl_t BoothPos2 = 3'b010;
    localparam booth_ctrl_t BoothNeg1 = 3'b100;
    localparam booth_ctrl_t BoothNeg2 = 3'b110;

endpackage

// File: rtl/booth_r4_enc.sv
// Radix-4 Booth recoder: maps {b[i+1], b[i], b[i-1]} to a digit in {-2,-1,0,+1,+2}.
module booth_r4_enc
    import mult_pkg::*;
(
    input  logic [2:0] bits,
    output logic       neg,
    output logic       dbl,
    output logic       zero
);

    booth_ctrl_t ctrl;

    always_comb begin
        ctrl = BoothZero;
        case (bits)
            3'b000, 3'b111: ctrl = BoothZero;
            3'b001, 3'b010: ctrl = BoothPos1;
            3'b011:         ctrl = BoothPos2;
            3'b100:         ctrl = BoothNeg2;
            3'b101, 3'b110: ctrl = BoothNeg1;
            default:        ctrl = BoothZero;
        endcase
    end

    assign neg  = ctrl.neg;
    assign dbl  = ctrl.dbl;
    assign zero = ctrl.zero;

endmodule

// File: rtl/seq_booth_mult.sv
// Sequential radix-4 Booth multiplier, signed or unsigned operands selected per operation.
// One Booth step per cycle over WIDTH/2+1 digits of the 2-bit-extended multiplier.
module seq_booth_mult
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   r,
    output logic                 done,
    output logic                 busy
);

    localparam int unsigned EW    = WIDTH + 2;
    localparam int unsigned AW    = WIDTH + 4;
    localparam int unsigned STEPS = WIDTH / 2 + 1;
    localparam int unsigned CW    = $clog2(WIDTH / 2 + 2);
    localparam logic [CW-1:0] LastStep = CW'(STEPS - 1);

    state_t               state_q, state_d;
    logic [EW-1:0]        m_q, m_d;
    logic [AW-1:0]        acc_q, acc_d;
    logic [EW-1:0]        mq_q, mq_d;
    logic                 prev_q, prev_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   r_q, r_d;

    logic [EW-1:0]        a_ext, b_ext;
    logic                 dig_neg, dig_dbl, dig_zero;
    logic [AW-1:0]        m_wide, m_sel, addend, sum;
    logic [AW-1:0]        acc_shift;
    logic [EW-1:0]        mq_shift;

    assign a_ext = {{2{signed_mode & a[WIDTH-1]}}, a};
    assign b_ext = {{2{signed_mode & b[WIDTH-1]}}, b};

    booth_r4_enc u_enc (
        .bits ({mq_q[1:0], prev_q}),
        .neg  (dig_neg),
        .dbl  (dig_dbl),
        .zero (dig_zero)
    );

    assign m_wide = {{2{m_q[EW-1]}}, m_q};
    assign m_sel  = dig_dbl ? (m_wide << 1) : m_wide;
    assign addend = dig_zero ? '0 : (dig_neg ? (~m_sel + 1'b1) : m_sel);
    assign sum    = acc_q + addend;

    // {acc, mq, prev} forms one register pair shifted right arithmetically by 2 per step
    assign acc_shift = {{2{sum[AW-1]}}, sum[AW-1:2]};
    assign mq_shift  = {sum[1:0], mq_q[EW-1:2]};

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        acc_d   = acc_q;
        mq_d    = mq_q;
        prev_d  = prev_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (start) begin
                    state_d = StCalc;
                    m_d     = a_ext;
                    mq_d    = b_ext;
                    acc_d   = '0;
                    prev_d  = 1'b0;
                    cnt_d   = '0;
                end
            end
            StCalc: begin
                acc_d  = acc_shift;
                mq_d   = mq_shift;
                prev_d = mq_q[1];
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LastStep) begin
                    state_d = StDone;
                    // After EW bits of shift the low product bits occupy mq entirely
                    r_d     = {acc_shift[WIDTH-3:0], mq_shift};
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            m_q     <= '0;
            acc_q   <= '0;
            mq_q    <= '0;
            prev_q  <= 1'b0;
            cnt_q   <= '0;
            r_q     <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            acc_q   <= acc_d;
            mq_q    <= mq_d;
            prev_q  <= prev_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
        end
    end

    assign r    = r_q;
    assign done = (state_q == StDone);
    assign busy = (state_q == StCalc);

endmodule

// File: tb/tb_seq_booth_mult.sv
// Directed, table-driven bench for seq_booth_mult at WIDTH=8 and WIDTH=16.
module tb_seq_booth_mult;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic        start8 = 1'b0, sm8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [15:0] r8;
    logic        done8, busy8;

    logic        start16 = 1'b0, sm16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic [31:0] r16;
    logic        done16, busy16;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    seq_booth_mult #(.WIDTH(8)) dut8 (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start8),
        .signed_mode (sm8),
        .a           (a8),
        .b           (b8),
        .r           (r8),
        .done        (done8),
        .busy        (busy8)
    );

    seq_booth_mult #(.WIDTH(16)) dut16 (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start16),
        .signed_mode (sm16),
        .a           (a16),
        .b           (b16),
        .r           (r16),
        .done        (done16),
        .busy        (busy16)
    );

    typedef struct {
        logic        sm;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] p;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic wait_done8(output int n);
        n = 0;
        while (!done8 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic wait_done16(output int n);
        n = 0;
        while (!done16 && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic run8(input string name, input logic sm, input logic [7:0] a,
                        input logic [7:0] b, input logic [15:0] exp);
        int n;
        @(negedge clk);
        sm8 = sm; a8 = a; b8 = b; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        // scramble operands after acceptance; result must not move
        a8 = 8'($urandom); b8 = 8'($urandom); sm8 = ~sm;
        check({name, " busy after accept"}, 64'(busy8), 64'd1);
        wait_done8(n);
        check({name, " latency"}, 64'(n), 64'd5);
        check({name, " product"}, 64'(r8), 64'(exp));
        check({name, " busy in done"}, 64'(busy8), 64'd0);
        @(posedge clk); #1;
        check({name, " done pulse width"}, 64'(done8), 64'd0);
        check({name, " r hold"}, 64'(r8), 64'(exp));
    endtask

    initial begin
        int  n;
        bit  seen;

        vecs[0]  = '{1'b1, 8'hFE, 8'hF1, 16'h001E};
        vecs[1]  = '{1'b0, 8'hFF, 8'hFF, 16'hFE01};
        vecs[2]  = '{1'b1, 8'hFF, 8'hFF, 16'h0001};
        vecs[3]  = '{1'b1, 8'h80, 8'h80, 16'h4000};
        vecs[4]  = '{1'b1, 8'h80, 8'h00, 16'h0000};
        vecs[5]  = '{1'b1, 8'h80, 8'h01, 16'hFF80};
        vecs[6]  = '{1'b0, 8'h80, 8'h80, 16'h4000};
        vecs[7]  = '{1'b0, 8'h0F, 8'h10, 16'h00F0};
        vecs[8]  = '{1'b1, 8'h7F, 8'h81, 16'hC0FF};
        vecs[9]  = '{1'b0, 8'h7F, 8'h81, 16'h3FFF};
        vecs[10] = '{1'b1, 8'hFF, 8'h01, 16'hFFFF};
        vecs[11] = '{1'b1, 8'h05, 8'hFD, 16'hFFF1};

        #3;
        check("reset r8", 64'(r8), 64'd0);
        check("reset done8", 64'(done8), 64'd0);
        check("reset busy8", 64'(busy8), 64'd0);
        check("reset r16", 64'(r16), 64'd0);
        check("reset busy16", 64'(busy16), 64'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run8($sformatf("vec%0d", i), vecs[i].sm, vecs[i].a, vecs[i].b, vecs[i].p);
        end

        // start re-asserted mid-calculation with different operands is ignored
        @(negedge clk);
        sm8 = 1'b1; a8 = 8'hFE; b8 = 8'hF1; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        n = 0;
        while (!done8 && n < 20) begin
            @(posedge clk); #1;
            n++;
            if (n == 2) begin
                start8 = 1'b1; sm8 = 1'b0; a8 = 8'h07; b8 = 8'h09;
            end else begin
                start8 = 1'b0;
            end
        end
        check("ignored start latency", 64'(n), 64'd5);
        check("ignored start product", 64'(r8), 64'h001E);
        @(posedge clk); #1;
        check("ignored start then idle", 64'(busy8), 64'd0);

        // reset mid-calculation
        @(negedge clk);
        sm8 = 1'b1; a8 = 8'h7F; b8 = 8'h81; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort r", 64'(r8), 64'd0);
        check("abort busy", 64'(busy8), 64'd0);
        check("abort done", 64'(done8), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (done8 || busy8) seen = 1'b1;
        end
        check("no done after abort", 64'(seen), 64'd0);
        run8("after abort", 1'b1, 8'h7F, 8'h81, 16'hC0FF);

        // WIDTH=16 with back-to-back start from DONE
        @(negedge clk);
        sm16 = 1'b1; a16 = 16'h8000; b16 = 16'h7FFF; start16 = 1'b1;
        @(posedge clk); #1;
        start16 = 1'b0;
        wait_done16(n);
        check("w16 latency", 64'(n), 64'd9);
        check("w16 product", 64'(r16), 64'hC0008000);
        sm16 = 1'b0; a16 = 16'hFFFF; b16 = 16'hFFFF; start16 = 1'b1;
        @(posedge clk); #1;
        start16 = 1'b0;
        check("w16 b2b busy", 64'(busy16), 64'd1);
        check("w16 b2b done low", 64'(done16), 64'd0);
        check("w16 b2b r held", 64'(r16), 64'hC0008000);
        wait_done16(n);
        check("w16 b2b latency", 64'(n), 64'd9);
        check("w16 b2b product", 64'(r16), 64'hFFFE0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/seq_booth_mult.md
SEQ_BOOTH_MULT -- requirements
Module: seq_booth_mult

Interface
REQ-001 Parameter WIDTH, default 8: operand width; SHALL be even and >= 4.
REQ-002 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  request; sampled on the rising edge of clk.
REQ-005 signed_mode  input  1  1 = two's-complement operands; 0 = unsigned operands.
REQ-006 a  input  WIDTH  multiplicand.
REQ-007 b  input  WIDTH  multiplier.
REQ-008 r  output  2*WIDTH  product; registered.
REQ-009 done  output  1  one-cycle pulse; r is valid when it rises.
REQ-010 busy  output  1  high while a computation is in progress.

Function
REQ-011 States SHALL be IDLE, CALC and DONE.
REQ-012 Start acceptance SHALL occur when start=1 at a rising edge in IDLE or DONE.
REQ-013 On acceptance, a, b and signed_mode SHALL be latched and the state SHALL go to CALC.
REQ-014 Both latched operands SHALL be extended to WIDTH+2 bits: sign-extended if signed_mode=1, zero-extended otherwise.
REQ-015 CALC SHALL perform one radix-4 Booth step per cycle.
- Each step: recode 3 multiplier bits to a digit in {-2,-1,0,+1,+2}; add the selected multiple to the accumulator; arithmetic-shift by 2.
- Step count: exactly WIDTH/2+1.
REQ-016 Edge counting SHALL be as follows.
- Acceptance at edge E0.
- The final step completes at edge E0+WIDTH/2+1, which loads r, enters DONE and raises done.
- Latency: 5 cycles for WIDTH=8.
REQ-017 done SHALL be high only in DONE, for exactly one cycle unless back-to-back starts occur.
REQ-018 busy SHALL be high only in CALC.
REQ-019 r SHALL equal the exact product, truncated to 2*WIDTH bits; no overflow is possible.
REQ-020 r SHALL hold its value from the DONE entry until the next DONE entry.
REQ-021 start while in CALC SHALL be ignored; the operation in flight SHALL be unaffected.
REQ-022 From DONE, the state SHALL go to CALC if start=1, else to IDLE.
REQ-023 Operand changes after acceptance SHALL NOT affect the result.

Reset
REQ-024 rst_n=0 SHALL immediately force the state to IDLE, r to 0, done to 0 and busy to 0, independent of clk.
REQ-025 Reset mid-CALC SHALL abort the operation; no done pulse SHALL follow.
REQ-026 The first start after rst_n deasserts SHALL behave as a fresh operation.

Structure
REQ-027 Shared package mult_pkg SHALL hold the state typedef and the Booth digit encoding constants.
REQ-028 Radix-4 recoding SHALL be a combinational sub-module booth_r4_enc: 3 multiplier bits in; negate, double and zero controls out.
REQ-029 A single datapath SHALL be used: accumulator/multiplier shift register plus a step counter of clog2(WIDTH/2+2) bits.

Verification
REQ-030 WIDTH=8, signed_mode=1, a=-2, b=-15 -> r=16'h001E and done 5 cycles after acceptance.
REQ-031 WIDTH=8, a=8'hFF, b=8'hFF -> r=16'hFE01 with signed_mode=0; r=16'h0001 with signed_mode=1.
REQ-032 WIDTH=8, signed_mode=1, a=8'h80, b=8'h80 -> r=16'h4000; with b=0 -> r=0; with b=1 -> r equals sign-extended a.
REQ-033 start pulsed again 2 cycles into CALC with new operands -> ignored; the first result is delivered unchanged at the original done cycle.
REQ-034 rst_n low for 1 cycle mid-CALC -> r=0, busy=0, no done; a new start then yields the correct product.
REQ-035 WIDTH=16, signed_mode=1, a=16'h8000, b=16'h7FFF -> r=32'hC0008000 after 9 cycles; back-to-back start in DONE -> no idle gap.
